// File: rtl/mmio_timer_if.sv
// CPU data-bus view of the memory-mapped timer: address, write strobe/data,
// combinational read data, window select and interrupt line.
interface mmio_timer_if;
    logic [31:0] addr;
    logic        wr_sig;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        sel;
    logic        irq;

    modport master (
        output addr, wr_sig, wr_data,
        input  rd_data, sel, irq
    );

    modport slave (
        input  addr, wr_sig, wr_data,
        output rd_data, sel, irq
    );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit up-counter with compare match, overflow flag,
// auto-reload/one-shot modes and a level-sensitive interrupt.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned PRESCALE_W = 8
) (
    input logic         clk,
    input logic         reset_n,
    mmio_timer_if.slave bus
);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_COUNT  = 2'd1,
        REG_CMP    = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    logic                  en;
    logic                  auto_rl;
    logic                  irq_en;
    logic [PRESCALE_W-1:0] presc;
    logic [PRESCALE_W-1:0] pcnt;
    logic [31:0]           count;
    logic [31:0]           cmp;
    logic                  match;
    logic                  ovf;

    reg_e  offset;
    logic  wr_en;
    logic  wr_ctrl;
    logic  wr_count;
    logic  wr_cmp;
    logic  wr_status;
    logic  tick;
    logic  hit;
    logic  unused_addr_lsbs;

    assign bus.sel   = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign offset    = reg_e'(bus.addr[3:2]);
    assign wr_en     = bus.wr_sig && bus.sel;
    assign wr_ctrl   = wr_en && (offset == REG_CTRL);
    assign wr_count  = wr_en && (offset == REG_COUNT);
    assign wr_cmp    = wr_en && (offset == REG_CMP);
    assign wr_status = wr_en && (offset == REG_STATUS);

    assign tick = en && (pcnt == presc);
    assign hit  = (count == cmp);

    assign bus.irq = match && irq_en;

    assign unused_addr_lsbs = &{1'b0, bus.addr[1:0]};

    always_comb begin
        bus.rd_data = '0;
        if (bus.sel) begin
            case (offset)
                REG_CTRL: begin
                    bus.rd_data[0]               = en;
                    bus.rd_data[1]               = auto_rl;
                    bus.rd_data[2]               = irq_en;
                    bus.rd_data[8 +: PRESCALE_W] = presc;
                end
                REG_COUNT:  bus.rd_data = count;
                REG_CMP:    bus.rd_data = cmp;
                REG_STATUS: bus.rd_data[1:0] = {ovf, match};
                default:    bus.rd_data = '0;
            endcase
        end
    end

    // Software writes take priority over tick updates except for the STATUS
    // flags, where a hardware set in the same cycle beats the W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en      <= 1'b0;
            auto_rl <= 1'b0;
            irq_en  <= 1'b0;
            presc   <= '0;
            pcnt    <= '0;
            count   <= '0;
            cmp     <= '1;
            match   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (wr_ctrl || !en || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end

            if (wr_ctrl) begin
                en      <= bus.wr_data[0];
                auto_rl <= bus.wr_data[1];
                irq_en  <= bus.wr_data[2];
                presc   <= bus.wr_data[8 +: PRESCALE_W];
            end else if (tick && hit && !auto_rl) begin
                en <= 1'b0;
            end

            if (wr_count) begin
                count <= bus.wr_data;
            end else if (tick) begin
                if (hit) begin
                    if (auto_rl) begin
                        count <= '0;
                    end
                end else begin
                    count <= count + 32'd1;
                end
            end

            if (wr_cmp) begin
                cmp <= bus.wr_data;
            end

            if (tick && hit) begin
                match <= 1'b1;
            end else if (wr_status && bus.wr_data[0]) begin
                match <= 1'b0;
            end

            if (tick && !hit && (count == '1)) begin
                ovf <= 1'b1;
            end else if (wr_status && bus.wr_data[1]) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer: reset values, auto-reload,
// prescaled one-shot, wrap/overflow, IRQ with W1C races, and address decode.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0;
    localparam logic [31:0] A_COUNT  = BASE + 32'h4;
    localparam logic [31:0] A_CMP    = BASE + 32'h8;
    localparam logic [31:0] A_STATUS = BASE + 32'hC;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    mmio_timer_if bus ();

    mmio_timer #(
        .BASE_ADDR  (BASE),
        .PRESCALE_W (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running required done");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h required %08h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(tag, bus.rd_data, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr_sig  = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_sig  = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_cnt;
        n_checks    = 0;
        n_pass      = 0;
        reset_n     = 1'b0;
        bus.addr    = '0;
        bus.wr_sig  = 1'b0;
        bus.wr_data = '0;

        // 1: reset values
        repeat (3) @(posedge clk);
        #2;
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_count", A_COUNT, 32'h0);
        rd_chk("rst_cmp", A_CMP, 32'hFFFF_FFFF);
        rd_chk("rst_status", A_STATUS, 32'h0);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // 2: auto-reload, PRESC=0
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h3);
        rd_chk("ar_count0", A_COUNT, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            exp_cnt = (k == 4) ? 32'd0 : k;
            rd_chk("ar_count", A_COUNT, exp_cnt);
            rd_chk("ar_status", A_STATUS, (k == 4) ? 32'h1 : 32'h0);
        end
        wr(A_STATUS, 32'h1);
        rd_chk("ar_clr_status", A_STATUS, 32'h0);
        rd_chk("ar_clr_count", A_COUNT, 32'd1);
        cyc();
        cyc();
        rd_chk("ar_pre_rematch", A_STATUS, 32'h0);
        cyc();
        rd_chk("ar_rematch", A_STATUS, 32'h1);
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h3);
        wr(A_COUNT, 32'h0);

        // 3: prescale 2, one-shot
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'h0201);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            exp_cnt = (k / 3 > 2) ? 32'd2 : k / 3;
            if (k == 2 || k == 3 || k == 5 || k == 6 || k == 12) begin
                rd_chk("os_count", A_COUNT, exp_cnt);
            end
            if (k == 8) begin
                rd_chk("os_no_match", A_STATUS, 32'h0);
            end
            if (k == 9) begin
                rd_chk("os_match", A_STATUS, 32'h1);
                rd_chk("os_en_clr", A_CTRL, 32'h0200);
            end
        end
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h3);

        // 4: wrap and overflow
        wr(A_COUNT, 32'hFFFF_FFFE);
        wr(A_CMP, 32'h0);
        wr(A_CTRL, 32'h3);
        rd_chk("wr_count0", A_COUNT, 32'hFFFF_FFFE);
        cyc();
        rd_chk("wr_count1", A_COUNT, 32'hFFFF_FFFF);
        rd_chk("wr_status1", A_STATUS, 32'h0);
        cyc();
        rd_chk("wr_count2", A_COUNT, 32'h0);
        rd_chk("wr_ovf", A_STATUS, 32'h2);
        cyc();
        rd_chk("wr_match", A_STATUS, 32'h3);
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h3);

        // 5: irq and W1C races
        wr(A_COUNT, 32'h0);
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h7);
        cyc();
        cyc();
        cyc();
        check("irq_pre", {31'b0, bus.irq}, 32'h0);
        cyc();
        check("irq_set", {31'b0, bus.irq}, 32'h1);
        wr(A_STATUS, 32'h1);
        check("irq_w1c", {31'b0, bus.irq}, 32'h0);
        cyc();
        cyc();
        wr(A_STATUS, 32'h1);
        rd_chk("w1c_race_status", A_STATUS, 32'h1);
        check("w1c_race_irq", {31'b0, bus.irq}, 32'h1);
        wr(A_CTRL, 32'h0300);
        check("irq_en_clr", {31'b0, bus.irq}, 32'h0);
        rd_chk("stop_count", A_COUNT, 32'd1);
        cyc();
        cyc();
        rd_chk("stop_hold", A_COUNT, 32'd1);

        // 6: decode outside the window
        @(negedge clk);
        bus.addr    = BASE + 32'h10;
        bus.wr_data = 32'h0;
        bus.wr_sig  = 1'b1;
        #1;
        check("dec_hi_sel", {31'b0, bus.sel}, 32'h0);
        check("dec_hi_rd", bus.rd_data, 32'h0);
        @(posedge clk);
        #1;
        bus.wr_sig  = 1'b0;
        @(negedge clk);
        bus.addr    = BASE - 32'h4;
        bus.wr_data = 32'hFFFF_FFFF;
        bus.wr_sig  = 1'b1;
        #1;
        check("dec_lo_sel", {31'b0, bus.sel}, 32'h0);
        check("dec_lo_rd", bus.rd_data, 32'h0);
        @(posedge clk);
        #1;
        bus.wr_sig  = 1'b0;
        rd_chk("dec_ctrl", A_CTRL, 32'h0300);
        rd_chk("dec_count", A_COUNT, 32'd1);
        rd_chk("dec_cmp", A_CMP, 32'd3);
        rd_chk("dec_status", A_STATUS, 32'h1);
        check("dec_in_sel", {31'b0, bus.sel}, 32'h1);

        // reset asserted while counting
        wr(A_CTRL, 32'h7);
        cyc();
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        rd_chk("mid_rst_ctrl", A_CTRL, 32'h0);
        rd_chk("mid_rst_count", A_COUNT, 32'h0);
        rd_chk("mid_rst_cmp", A_CMP, 32'hFFFF_FFFF);
        rd_chk("mid_rst_status", A_STATUS, 32'h0);
        check("mid_rst_irq", {31'b0, bus.irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
